// File: rtl/rst_seq_pkg.sv
// Shared types for the core reset sequencer: sequencer states and retry counter width.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STRETCH,
    RELEASE,
    RUN,
    PLL_RST
  } state_e;

  localparam int RETRY_W = 4;

endpackage

// File: rtl/rst_seq_boolean_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/rst_seq_boolean.sv
// Core reset sequencer: waits for PLL lock, stretches, then releases domains one by one.
module rst_seq_boolean
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_locked,
  input  logic                   i_sw_rst_req,
  output logic [NUM_DOMAINS-1:0] o_rst,
  output logic                   o_pll_rst,
  output logic                   o_ready,
  output logic [RETRY_W-1:0]     o_retry_cnt
);

  localparam int LT_W  = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
  localparam int ST_W  = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam int PR_W  = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int M1_W  = (LT_W > ST_W) ? LT_W : ST_W;
  // One shared phase counter; each state only uses the range its parameter defines.
  localparam int CNT_W = (M1_W > PR_W) ? M1_W : PR_W;
  localparam int GAP_W = (STAGE_GAP   > 1) ? $clog2(STAGE_GAP)   : 1;
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   pll_q, pll_d;
  logic                   ready_q, ready_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic                   locked_s;

  sync_2ff u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_locked),
    .o_q   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    pll_d   = 1'b0;
    ready_d = 1'b0;
    retry_d = retry_q;
    if (i_sw_rst_req && state_q != PLL_RST) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      rst_d   = '1;
      pll_d   = 1'b1;
    end else if (!locked_s && (state_q == STRETCH || state_q == RELEASE || state_q == RUN)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_d = '1;
          if (locked_s) begin
            state_d = STRETCH;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            pll_d   = 1'b1;
            if (retry_q != '1) retry_d = retry_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STRETCH: begin
          if (cnt_q == STRETCH_LAST) begin
            // Domain 0 drops on the edge that leaves STRETCH; later domains follow every STAGE_GAP.
            rst_d[0] = 1'b0;
            cnt_d    = '0;
            gap_d    = '0;
            idx_d    = IDX_W'(1);
            state_d  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            ready_d  = (NUM_DOMAINS == 1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_LAST) begin
            rst_d[idx_q] = 1'b0;
            gap_d        = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        PLL_RST: begin
          rst_d = '1;
          if (cnt_q == PLL_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            pll_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          rst_d   = '1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      pll_q   <= 1'b0;
      ready_q <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      pll_q   <= pll_d;
      ready_q <= ready_d;
      retry_q <= retry_d;
    end
  end

  assign o_rst       = rst_q;
  assign o_pll_rst   = pll_q;
  assign o_ready     = ready_q;
  assign o_retry_cnt = retry_q;

endmodule
